// File: rtl/wm_pkg.sv
// Shared types for the washing-machine sequencer.
// The state encoding is fixed here so every user agrees on it.
package wm_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        DETERGENT = 3'd2,
        WASH      = 3'd3,
        DRAIN     = 3'd4,
        SPIN      = 3'd5,
        DONE      = 3'd6
    } wm_state_t;

endpackage

// File: rtl/iiitb_wm.sv
// Washing-machine sequencer: soap pass, rinse pass, spin, then a one-cycle done pulse.
// Actuator outputs are Moore-decoded from the state register only.
module iiitb_wm
    import wm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic door_close,
    input  logic start,
    input  logic filled,
    input  logic detergent_added,
    input  logic cycle_timeout,
    input  logic drained,
    input  logic spin_timeout,
    output logic door_lock,
    output logic motor_on,
    output logic fill_value_on,
    output logic drain_value_on,
    output logic done,
    output logic soap_wash,
    output logic water_wash
);

    wm_state_t state_q, state_d;
    logic      soap_q, soap_d;
    logic      water_q, water_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            soap_q  <= 1'b0;
            water_q <= 1'b0;
        end else begin
            state_q <= state_d;
            soap_q  <= soap_d;
            water_q <= water_d;
        end
    end

    // Only the current state's exit input is examined.
    always_comb begin
        state_d = state_q;
        soap_d  = soap_q;
        water_d = water_q;
        case (state_q)
            IDLE: begin
                if (start && door_close) state_d = FILL;
            end
            FILL: begin
                if (filled) state_d = soap_q ? WASH : DETERGENT;
            end
            DETERGENT: begin
                if (detergent_added) begin
                    state_d = WASH;
                    soap_d  = 1'b1;
                end
            end
            WASH: begin
                if (cycle_timeout) state_d = DRAIN;
            end
            DRAIN: begin
                if (drained) begin
                    if (water_q) begin
                        state_d = SPIN;
                    end else begin
                        state_d = FILL;
                        water_d = 1'b1;
                    end
                end
            end
            SPIN: begin
                if (spin_timeout) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                soap_d  = 1'b0;
                water_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        door_lock      = 1'b0;
        motor_on       = 1'b0;
        fill_value_on  = 1'b0;
        drain_value_on = 1'b0;
        done           = 1'b0;
        case (state_q)
            FILL: begin
                door_lock     = 1'b1;
                fill_value_on = 1'b1;
            end
            DETERGENT: begin
                door_lock = 1'b1;
            end
            WASH: begin
                door_lock = 1'b1;
                motor_on  = 1'b1;
            end
            DRAIN: begin
                door_lock      = 1'b1;
                drain_value_on = 1'b1;
            end
            SPIN: begin
                door_lock      = 1'b1;
                motor_on       = 1'b1;
                drain_value_on = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign soap_wash  = soap_q;
    assign water_wash = water_q;

endmodule

// File: tb/tb_iiitb_wm.sv
// Scoreboard bench for iiitb_wm: stimulus queues the expected output vector after each edge,
// a negedge monitor pops and compares it against the DUT.
module tb_iiitb_wm;

    logic clk = 1'b0;
    logic reset, door_close, start, filled, detergent_added;
    logic cycle_timeout, drained, spin_timeout;
    logic door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash;

    iiitb_wm dut (
        .clk             (clk),
        .reset           (reset),
        .door_close      (door_close),
        .start           (start),
        .filled          (filled),
        .detergent_added (detergent_added),
        .cycle_timeout   (cycle_timeout),
        .drained         (drained),
        .spin_timeout    (spin_timeout),
        .door_lock       (door_lock),
        .motor_on        (motor_on),
        .fill_value_on   (fill_value_on),
        .drain_value_on  (drain_value_on),
        .done            (done),
        .soap_wash       (soap_wash),
        .water_wash      (water_wash)
    );

    always #5 clk = ~clk;

    // Actuators {door_lock, motor_on, fill_value_on, drain_value_on, done}
    localparam logic [4:0] A_IDLE  = 5'b00000;
    localparam logic [4:0] A_FILL  = 5'b10100;
    localparam logic [4:0] A_DET   = 5'b10000;
    localparam logic [4:0] A_WASH  = 5'b11000;
    localparam logic [4:0] A_DRAIN = 5'b10010;
    localparam logic [4:0] A_SPIN  = 5'b11010;
    localparam logic [4:0] A_DONE  = 5'b00001;

    // Inputs {door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout}
    localparam logic [6:0] I_NONE  = 7'b0000000;
    localparam logic [6:0] I_GO    = 7'b1100000;
    localparam logic [6:0] I_START = 7'b0100000;
    localparam logic [6:0] I_FILL  = 7'b0010000;
    localparam logic [6:0] I_DET   = 7'b0001000;
    localparam logic [6:0] I_CYC   = 7'b0000100;
    localparam logic [6:0] I_DRN   = 7'b0000010;
    localparam logic [6:0] I_SPIN  = 7'b0000001;
    localparam logic [6:0] I_ALL   = 7'b1111111;

    logic [6:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    string tag = "reset";

    // Drive one cycle of inputs, then queue the outputs required after the edge.
    task automatic cyc(input logic rst, input logic [6:0] in, input logic [4:0] act,
                       input logic s, input logic w);
        reset = rst;
        {door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout} = in;
        @(posedge clk);
        exp_q.push_back({act, s, w});
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [6:0] got, want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {door_lock, motor_on, fill_value_on, drain_value_on, done,
                    soap_wash, water_wash};
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s @%0t: outputs %b, required %b", tag, $time, got, want);
            end
        end
    end

    initial begin
        // 1: reset, then idle
        tag = "reset";
        cyc(1'b1, I_NONE, A_IDLE, 1'b0, 1'b0);
        cyc(1'b1, I_NONE, A_IDLE, 1'b0, 1'b0);
        tag = "idle_hold";
        for (int i = 0; i < 10; i++) cyc(1'b0, I_NONE, A_IDLE, 1'b0, 1'b0);

        // 2: start without door does nothing; then door closes
        tag = "start_no_door";
        for (int i = 0; i < 5; i++) cyc(1'b0, I_START, A_IDLE, 1'b0, 1'b0);
        tag = "door_lone";
        cyc(1'b0, 7'b1000000, A_IDLE, 1'b0, 1'b0);
        tag = "enter_fill";
        cyc(1'b0, I_GO, A_FILL, 1'b0, 1'b0);

        // 3: full run with single-cycle sensor pulses and some hold cycles
        tag = "fill_hold";
        cyc(1'b0, I_NONE, A_FILL, 1'b0, 1'b0);
        tag = "to_det";
        cyc(1'b0, I_FILL, A_DET, 1'b0, 1'b0);
        tag = "det_hold";
        cyc(1'b0, I_CYC, A_DET, 1'b0, 1'b0);
        tag = "to_wash1";
        cyc(1'b0, I_DET, A_WASH, 1'b1, 1'b0);
        tag = "to_drain1";
        cyc(1'b0, I_CYC, A_DRAIN, 1'b1, 1'b0);
        tag = "to_fill2";
        cyc(1'b0, I_DRN, A_FILL, 1'b1, 1'b1);
        tag = "to_wash2";
        cyc(1'b0, I_FILL, A_WASH, 1'b1, 1'b1);
        tag = "wash_hold";
        cyc(1'b0, I_NONE, A_WASH, 1'b1, 1'b1);
        tag = "to_drain2";
        cyc(1'b0, I_CYC, A_DRAIN, 1'b1, 1'b1);
        tag = "to_spin";
        cyc(1'b0, I_DRN, A_SPIN, 1'b1, 1'b1);
        tag = "spin_hold";
        cyc(1'b0, I_NONE, A_SPIN, 1'b1, 1'b1);
        tag = "to_done";
        cyc(1'b0, I_SPIN, A_DONE, 1'b1, 1'b1);
        tag = "done_to_idle";
        cyc(1'b0, I_NONE, A_IDLE, 1'b0, 1'b0);
        cyc(1'b0, I_NONE, A_IDLE, 1'b0, 1'b0);

        // 4: everything high, one state per cycle, then restart
        tag = "all_high";
        cyc(1'b0, I_ALL, A_FILL,  1'b0, 1'b0);
        cyc(1'b0, I_ALL, A_DET,   1'b0, 1'b0);
        cyc(1'b0, I_ALL, A_WASH,  1'b1, 1'b0);
        cyc(1'b0, I_ALL, A_DRAIN, 1'b1, 1'b0);
        cyc(1'b0, I_ALL, A_FILL,  1'b1, 1'b1);
        cyc(1'b0, I_ALL, A_WASH,  1'b1, 1'b1);
        cyc(1'b0, I_ALL, A_DRAIN, 1'b1, 1'b1);
        cyc(1'b0, I_ALL, A_SPIN,  1'b1, 1'b1);
        cyc(1'b0, I_ALL, A_DONE,  1'b1, 1'b1);
        cyc(1'b0, I_ALL, A_IDLE,  1'b0, 1'b0);
        tag = "all_high_restart";
        cyc(1'b0, I_ALL, A_FILL,  1'b0, 1'b0);
        cyc(1'b0, I_ALL, A_DET,   1'b0, 1'b0);
        tag = "reset_after_all";
        cyc(1'b1, I_NONE, A_IDLE, 1'b0, 1'b0);

        // 5: reset mid-wash
        tag = "to_wash_r";
        cyc(1'b0, I_GO,   A_FILL, 1'b0, 1'b0);
        cyc(1'b0, I_FILL, A_DET,  1'b0, 1'b0);
        cyc(1'b0, I_DET,  A_WASH, 1'b1, 1'b0);
        tag = "reset_in_wash";
        cyc(1'b1, I_CYC,  A_IDLE, 1'b0, 1'b0);
        tag = "after_reset";
        cyc(1'b0, I_NONE, A_IDLE, 1'b0, 1'b0);

        // 6: door open / spin_timeout ignored in DRAIN
        tag = "to_drain_d";
        cyc(1'b0, I_GO,   A_FILL,  1'b0, 1'b0);
        cyc(1'b0, I_FILL, A_DET,   1'b0, 1'b0);
        cyc(1'b0, I_DET,  A_WASH,  1'b1, 1'b0);
        cyc(1'b0, I_CYC,  A_DRAIN, 1'b1, 1'b0);
        tag = "drain_ignore";
        for (int i = 0; i < 3; i++) cyc(1'b0, I_SPIN, A_DRAIN, 1'b1, 1'b0);
        tag = "drain_exit";
        cyc(1'b0, I_DRN,  A_FILL,  1'b1, 1'b1);
        tag = "final_reset";
        cyc(1'b1, I_NONE, A_IDLE,  1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_queue: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
